im_fetch_seq: RTL and testbench
===============================

# im_fetch_seq

Sequential, parametrised item-memory fetch unit for the sparse-HDC encoder. It holds a writable level-hypervector LUT of `LEVELS` entries, accepts one quantized sample vector of `CH` channel levels through a valid/ready handshake, and streams the `CH` matching level hypervectors out one per cycle, tagged with channel index and a last flag. It sits between the quantizer and the binding/bundling stage.

## Interface
Parameters:
- `HV_W`, 10, hypervector width in bits
- `LEVELS`, 10, number of LUT entries (quantization levels), ≥2
- `CH`, 4, channels per input vector, ≥1
- `QW`, 4, qlevel field width, ≥ clog2(LEVELS)
- `CW`, 2, channel index width, max(1, clog2(CH))

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge
- `rst` in 1 — synchronous, active-high reset
- `lut_we` in 1 — LUT write enable
- `lut_waddr` in QW — LUT write address
- `lut_wdata` in HV_W — LUT write data
- `in_valid` in 1 — input vector valid
- `in_ready` out 1 — unit can accept a vector
- `in_qlevel` in CH*QW — channel c level at bits [c*QW +: QW]
- `out_valid` out 1 — output beat valid
- `out_ready` in 1 — downstream accepts beat
- `out_hv` out HV_W — fetched level hypervector
- `out_ch` out CW — channel index of beat
- `out_last` out 1 — beat is channel CH-1
- `out_err` out 1 — beat's qlevel was ≥ LEVELS

## Operation
- States: IDLE, STREAM.
- IDLE: `in_ready`=1, `out_valid`=0. On `in_valid && in_ready`, all CH qlevels are captured into an internal register, channel counter cleared to 0, go to STREAM.
- STREAM: `in_ready`=0. Output register holds the beat for current channel: `out_hv`=LUT[q] if q<LEVELS, else all-zero with `out_err`=1. `out_ch`=counter, `out_last`=(counter==CH-1).
- Beat transfers when `out_valid && out_ready`. On transfer of a non-last beat: counter+1, next beat loaded into the output register the same edge. On transfer of the last beat: `out_valid`→0, go to IDLE.
- No transfer: `out_hv`, `out_ch`, `out_last`, `out_err` hold stable (AXI-style; no change while stalled).
- LUT: LEVELS×HV_W registers. Write on `lut_we` when `lut_waddr` < LEVELS; out-of-range writes ignored. Writes allowed in any state.
- Read/write collision: a beat loaded on the same edge as a write to its entry takes the old (pre-write) contents. A beat already held in the output register is never altered by later writes.
- CH=1: single beat with `out_last`=1.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `in_ready`=1 from the following cycle, `out_valid`=0, `out_hv`=0, `out_ch`=0, `out_last`=0, `out_err`=0, counter 0, all LUT entries 0. Reset overrides a concurrent LUT write or handshake; reset mid-stream drops the vector with no further beats.
- Input accepted at edge T → beat ch0 valid in cycle T+1.
- With `out_ready` held 1: beat k valid in cycle T+1+k; last beat in cycle T+CH; `in_ready`=1 in cycle T+CH+1. Throughput one vector per CH+1 cycles.
- No combinational path from `in_valid` or `out_ready` to any output; all outputs registered.

## Test plan
- Reset: assert `rst` 2 cycles mid-stream → next cycle `out_valid`=0, `in_ready`=1, `out_hv`=0; fetch of level 3 afterwards returns 0 (LUT cleared).
- Basic stream: LUT[i]=10'h3FF>>i for i=0..9, input levels {ch3..ch0}={9,0,5,2}, `out_ready`=1 → cycles T+1..T+4 emit 10'h0FF, 10'h01F, 10'h3FF, 10'h001 with `out_ch` 0..3, `out_last` only on ch3, `in_ready` back at T+5.
- Backpressure: same input, `out_ready` low for 3 cycles at ch1 → ch1 beat (10'h01F, `out_ch`=1) held stable all 3 cycles, no beat skipped or duplicated.
- Out-of-range: levels {15,10,9,0} → ch2, ch3 beats `out_hv`=0, `out_err`=1; ch0, ch1 `out_err`=0; write to `lut_waddr`=12 leaves all entries unchanged.
- Write collision: during stream, write LUT[5]=10'h2AA on the edge loading the level-5 beat → beat shows old value; a subsequent vector with level 5 shows 10'h2AA.
- Input while busy: hold `in_valid`=1 with a second vector throughout the first stream → second vector captured only at edge T+CH+1, first vector's beats uncorrupted.

Source files
------------

// File: rtl/im_fetch_seq.sv
// im_fetch_seq: writable level-HV LUT that streams one fetched hypervector per channel of an accepted sample vector.
module im_fetch_seq #(
  parameter int HV_W   = 10,
  parameter int LEVELS = 10,
  parameter int CH     = 4,
  parameter int QW     = 4,
  parameter int CW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lut_we,
  input  logic [QW-1:0]     lut_waddr,
  input  logic [HV_W-1:0]   lut_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*QW-1:0]  in_qlevel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_W-1:0]   out_hv,
  output logic [CW-1:0]     out_ch,
  output logic              out_last,
  output logic              out_err
);
  localparam logic [QW:0]   LV   = (QW+1)'(LEVELS);
  localparam logic [CW-1:0] LAST = CW'(CH-1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [CH*QW-1:0] qreg;
  logic [HV_W-1:0] rd [2**QW];
  logic [QW-1:0] q;
  logic [CW-1:0] nxt;
  logic bad;
  // Unused LUT slots read as zero, so out-of-range levels fetch all-zero.
  for (genvar g = 0; g < 2**QW; g++) begin : g_rd
    if (g < LEVELS) begin : g_e
      logic [HV_W-1:0] e;
      always_ff @(posedge clk)
        if (rst) e <= '0;
        else if (lut_we && lut_waddr == QW'(g)) e <= lut_wdata;
      assign rd[g] = e;
    end else begin : g_z
      assign rd[g] = '0;
    end
  end
  // Remaining levels are shifted down so the next channel is always in the low field.
  assign q   = state == IDLE ? in_qlevel[QW-1:0] : qreg[QW-1:0];
  assign bad = {1'b0, q} >= LV;
  assign nxt = out_ch + CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_hv    <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      qreg      <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state     <= STREAM;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
        out_ch    <= '0;
        out_last  <= LAST == '0;
        out_hv    <= rd[q];
        out_err   <= bad;
        qreg      <= in_qlevel >> QW;
      end
    end else if (out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        out_ch    <= nxt;
        out_last  <= nxt == LAST;
        out_hv    <= rd[q];
        out_err   <= bad;
        qreg      <= qreg >> QW;
      end
    end
  end
endmodule

// File: tb/tb_im_fetch_seq.sv
// tb_im_fetch_seq: randomized and directed checks of im_fetch_seq against a channel-list reference model.
module tb_im_fetch_seq;
  localparam int HV_W = 10, LEVELS = 10, CH = 4, QW = 4, CW = 2;
  logic clk = 0, rst = 1;
  logic lut_we = 0, in_valid = 0, out_ready = 1;
  logic [QW-1:0] lut_waddr = 0;
  logic [HV_W-1:0] lut_wdata = 0;
  logic [CH*QW-1:0] in_qlevel = 0;
  logic in_ready, out_valid, out_last, out_err;
  logic [HV_W-1:0] out_hv;
  logic [CW-1:0] out_ch;
  int checks = 0, fails = 0;

  im_fetch_seq #(.HV_W(HV_W), .LEVELS(LEVELS), .CH(CH), .QW(QW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_qlevel(in_qlevel),
    .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv), .out_ch(out_ch),
    .out_last(out_last), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: a vector is a list of levels; beat k is LUT[level k] sampled when it is loaded.
  logic [HV_W-1:0] m_lut [LEVELS];
  int lv [CH];
  bit m_init = 0, busy = 0;
  int k = 0, qq;
  logic [HV_W-1:0] e_hv;
  bit e_err;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; busy = 0; k = 0;
      for (int i = 0; i < LEVELS; i++) m_lut[i] = '0;
    end else if (m_init) begin
      if (!busy) begin
        if (in_valid) begin
          for (int c = 0; c < CH; c++) lv[c] = int'(in_qlevel[c*QW +: QW]);
          busy = 1; k = 0;
          qq = lv[0]; e_hv = qq < LEVELS ? m_lut[qq] : '0; e_err = qq >= LEVELS;
        end
      end else if (out_ready) begin
        if (k == CH-1) busy = 0;
        else begin
          k++;
          qq = lv[k]; e_hv = qq < LEVELS ? m_lut[qq] : '0; e_err = qq >= LEVELS;
        end
      end
      if (lut_we && int'(lut_waddr) < LEVELS) m_lut[lut_waddr] = lut_wdata;
    end
    #1;
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(!busy));
      chk("out_valid", 32'(out_valid), 32'(busy));
      if (busy) begin
        chk("out_hv", 32'(out_hv), 32'(e_hv));
        chk("out_ch", 32'(out_ch), 32'(k));
        chk("out_last", 32'(out_last), 32'(k == CH-1));
        chk("out_err", 32'(out_err), 32'(e_err));
      end
    end
  end

  task automatic step; @(negedge clk); endtask

  task automatic start(input logic [CH*QW-1:0] v);
    in_valid = 1; in_qlevel = v; step; in_valid = 0;
  endtask

  initial begin
    step; step; rst = 0;
    for (int i = 0; i < LEVELS; i++) begin
      lut_we = 1; lut_waddr = QW'(i); lut_wdata = 10'h3FF >> i; step;
    end
    lut_we = 0;
    // basic stream {9,0,5,2}
    start({4'd9, 4'd0, 4'd5, 4'd2});
    chk("basic_ch0", 32'(out_hv), 32'h0FF); step;
    chk("basic_ch1", 32'(out_hv), 32'h01F); step;
    chk("basic_ch2", 32'(out_hv), 32'h3FF); chk("basic_nolast", 32'(out_last), 0); step;
    chk("basic_ch3", 32'(out_hv), 32'h001); chk("basic_last", 32'(out_last), 1); step;
    chk("basic_ready_back", 32'(in_ready), 1);
    // backpressure on ch1
    start({4'd9, 4'd0, 4'd5, 4'd2}); step;
    out_ready = 0;
    repeat (3) begin
      chk("bp_hv", 32'(out_hv), 32'h01F); chk("bp_ch", 32'(out_ch), 1); step;
    end
    out_ready = 1;
    chk("bp_hv_release", 32'(out_hv), 32'h01F);
    repeat (4) step;
    // out-of-range levels
    start({4'd15, 4'd10, 4'd9, 4'd0});
    chk("oor_err0", 32'(out_err), 0); step;
    chk("oor_err1", 32'(out_err), 0); step;
    chk("oor_hv2", 32'(out_hv), 0); chk("oor_err2", 32'(out_err), 1); step;
    chk("oor_err3", 32'(out_err), 1); step;
    lut_we = 1; lut_waddr = 4'd12; lut_wdata = 10'h3FF; step; lut_we = 0;
    start({4'd9, 4'd0, 4'd5, 4'd2});
    chk("oor_write_ignored", 32'(out_hv), 32'h0FF);
    repeat (4) step;
    // collision: write LUT[5] on the edge loading the level-5 beat
    in_valid = 1; in_qlevel = {4'd0, 4'd0, 4'd0, 4'd5};
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 10'h2AA; step;
    in_valid = 0; lut_we = 0;
    chk("coll_old", 32'(out_hv), 32'h01F);
    repeat (4) step;
    start({4'd0, 4'd0, 4'd0, 4'd5});
    chk("coll_new", 32'(out_hv), 32'h2AA);
    repeat (4) step;
    // second vector held valid throughout the first stream
    in_valid = 1; in_qlevel = {4'd1, 4'd2, 4'd3, 4'd4}; step;
    in_qlevel = {4'd9, 4'd8, 4'd7, 4'd6};
    chk("busy_first_ch0", 32'(out_hv), 32'h03F);
    repeat (4) begin chk("busy_not_ready", 32'(in_ready), 0); step; end
    chk("busy_ready_again", 32'(in_ready), 1); step;
    in_valid = 0;
    chk("busy_second_ch0", 32'(out_hv), 32'h00F); chk("busy_second_ch", 32'(out_ch), 0);
    repeat (4) step;
    // reset mid-stream
    out_ready = 0; start({4'd3, 4'd3, 4'd3, 4'd3}); step;
    rst = 1; step; step; rst = 0;
    chk("rst_valid", 32'(out_valid), 0); chk("rst_ready", 32'(in_ready), 1); chk("rst_hv", 32'(out_hv), 0);
    out_ready = 1;
    start({4'd0, 4'd0, 4'd0, 4'd3});
    chk("rst_lut_cleared", 32'(out_hv), 0); chk("rst_lut_valid", 32'(out_valid), 1);
    repeat (4) step;
    // randomized traffic
    repeat (600) begin
      rst = $urandom_range(0, 80) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_qlevel = (CH*QW)'($urandom);
      lut_we = $urandom_range(0, 2) == 0;
      lut_waddr = QW'($urandom);
      lut_wdata = HV_W'($urandom);
      step;
    end
    rst = 0; in_valid = 0; lut_we = 0; out_ready = 1;
    repeat (8) step;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
